// File: rtl/tl_xing_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tl_xing_rr_arbiter
//
// Round-robin arbiter that shares one TL-UL bus-crossing port (A/D channels,
// 64-bit data) between NUM_REQ = 1<<REQ_BITS clients. It drives the widget_in
// side of the width-widget/bus-xing coupler.
//
// A channel: one client is granted per cycle. The granted client's fields
// pass straight through, and its source is extended with the client index,
// out_a_bits_source = {grant_idx, client_source}. Two things keep the grant
// on one client. A multi-beat Put holds the grant until its last beat fires.
// A stalled (valid && !ready) message keeps the grant until it is accepted.
//
// D channel: responses are steered back by the top REQ_BITS bits of
// out_d_bits_source. Those bits are stripped before the source reaches the
// clients. All other D fields are broadcast to every client.
//
// Both channels have zero latency and no buffering.
//
// Ports
//   clock, reset          clock; asynchronous active-high reset
//   in_a_*                per-client A channels (packed, client i in slice i)
//   in_d_*                per-client D valid/ready, shared D payload
//   out_a_*               A channel towards the coupler
//   out_d_*               D channel from the coupler
//   perf_grants           (TL_XING_ARB_PERF_EN only) per-client 16-bit
//                         saturating count of completed A messages
//
// Build option
//   TL_XING_ARB_PERF_EN   adds the perf_grants port and its counters.
//                         Arbitration is identical with or without it.
// ----------------------------------------------------------------------------
module tl_xing_rr_arbiter #(
  parameter  int REQ_BITS  = 1,
  parameter  int SRC_W     = 5,
  parameter  int ADDR_W    = 31,
  localparam int NUM_REQ   = 1 << REQ_BITS,
  localparam int OUT_SRC_W = SRC_W + REQ_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  // client A channels
  input  logic [NUM_REQ-1:0]        in_a_valid,
  output logic [NUM_REQ-1:0]        in_a_ready,
  input  logic [3*NUM_REQ-1:0]      in_a_bits_opcode,
  input  logic [3*NUM_REQ-1:0]      in_a_bits_param,
  input  logic [3*NUM_REQ-1:0]      in_a_bits_size,
  input  logic [SRC_W*NUM_REQ-1:0]  in_a_bits_source,
  input  logic [ADDR_W*NUM_REQ-1:0] in_a_bits_address,
  input  logic [8*NUM_REQ-1:0]      in_a_bits_mask,
  input  logic [64*NUM_REQ-1:0]     in_a_bits_data,
  input  logic [NUM_REQ-1:0]        in_a_bits_corrupt,
  // client D channels
  input  logic [NUM_REQ-1:0]        in_d_ready,
  output logic [NUM_REQ-1:0]        in_d_valid,
  output logic [2:0]                in_d_bits_opcode,
  output logic [1:0]                in_d_bits_param,
  output logic [2:0]                in_d_bits_size,
  output logic [SRC_W-1:0]          in_d_bits_source,
  output logic                      in_d_bits_sink,
  output logic                      in_d_bits_denied,
  output logic [63:0]               in_d_bits_data,
  output logic                      in_d_bits_corrupt,
  // coupler A channel
  output logic                      out_a_valid,
  input  logic                      out_a_ready,
  output logic [2:0]                out_a_bits_opcode,
  output logic [2:0]                out_a_bits_param,
  output logic [2:0]                out_a_bits_size,
  output logic [OUT_SRC_W-1:0]      out_a_bits_source,
  output logic [ADDR_W-1:0]         out_a_bits_address,
  output logic [7:0]                out_a_bits_mask,
  output logic [63:0]               out_a_bits_data,
  output logic                      out_a_bits_corrupt,
  // coupler D channel
  input  logic                      out_d_valid,
  output logic                      out_d_ready,
  input  logic [2:0]                out_d_bits_opcode,
  input  logic [1:0]                out_d_bits_param,
  input  logic [2:0]                out_d_bits_size,
  input  logic [OUT_SRC_W-1:0]      out_d_bits_source,
  input  logic                      out_d_bits_sink,
  input  logic                      out_d_bits_denied,
  input  logic [63:0]               out_d_bits_data,
  input  logic                      out_d_bits_corrupt
`ifdef TL_XING_ARB_PERF_EN
  ,
  output logic [16*NUM_REQ-1:0]     perf_grants
`endif
);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;

  // Number of data beats in a message. Only Puts carry data. A 64-bit beat
  // holds 8 bytes, and size is capped at 6 (64 bytes, 8 beats).
  function automatic logic [3:0] beats_of(input logic [2:0] opcode,
                                          input logic [2:0] size);
    logic [2:0] sz;
    sz = (size > 3'd6) ? 3'd6 : size;
    if ((opcode == OP_PUT_FULL || opcode == OP_PUT_PARTIAL) && sz > 3'd3)
      return 4'd1 << (sz - 3'd3);
    return 4'd1;
  endfunction

  // Arbitration state
  logic [REQ_BITS-1:0] rr_ptr;      // next preferred client
  logic                locked;      // mid-burst: grant pinned to owner
  logic                held;        // stalled message: grant pinned to owner
  logic [REQ_BITS-1:0] owner;
  logic [2:0]          beats_left;  // beats still to fire after the current one

  logic [REQ_BITS-1:0] grant;
  logic [REQ_BITS-1:0] cand;

  // Scan from the highest offset down, so the client closest to rr_ptr is
  // the one left in grant. With no valid client, grant falls back to rr_ptr.
  // out_a_valid is then 0, so that fallback value has no effect.
  // NOTE: every variable written in always_comb is given a default first.
  // Otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant = rr_ptr;
    cand  = rr_ptr;
    if (locked || held) begin
      grant = owner;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = rr_ptr + REQ_BITS'(k);
        if (in_a_valid[cand]) grant = cand;
      end
    end
  end

  // Mux the granted client's A fields
  logic [2:0]        sel_opcode, sel_param, sel_size;
  logic [SRC_W-1:0]  sel_source;
  logic [ADDR_W-1:0] sel_address;
  logic [7:0]        sel_mask;
  logic [63:0]       sel_data;
  logic              sel_corrupt;

  always_comb begin
    sel_opcode  = '0;
    sel_param   = '0;
    sel_size    = '0;
    sel_source  = '0;
    sel_address = '0;
    sel_mask    = '0;
    sel_data    = '0;
    sel_corrupt = 1'b0;
    in_a_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (REQ_BITS'(i) == grant) begin
        sel_opcode    = in_a_bits_opcode[3*i +: 3];
        sel_param     = in_a_bits_param[3*i +: 3];
        sel_size      = in_a_bits_size[3*i +: 3];
        sel_source    = in_a_bits_source[SRC_W*i +: SRC_W];
        sel_address   = in_a_bits_address[ADDR_W*i +: ADDR_W];
        sel_mask      = in_a_bits_mask[8*i +: 8];
        sel_data      = in_a_bits_data[64*i +: 64];
        sel_corrupt   = in_a_bits_corrupt[i];
        in_a_ready[i] = out_a_ready & in_a_valid[i];
      end
    end
  end

  assign out_a_valid        = in_a_valid[grant];
  assign out_a_bits_opcode  = sel_opcode;
  assign out_a_bits_param   = sel_param;
  assign out_a_bits_size    = sel_size;
  assign out_a_bits_source  = {grant, sel_source};
  assign out_a_bits_address = sel_address;
  assign out_a_bits_mask    = sel_mask;
  assign out_a_bits_data    = sel_data;
  assign out_a_bits_corrupt = sel_corrupt;

  logic       a_fire;
  logic [3:0] grant_beats;
  logic       msg_done;

  assign a_fire      = out_a_valid & out_a_ready;
  assign grant_beats = beats_of(sel_opcode, sel_size);
  // A message completes on a single-beat fire or on the last burst beat
  assign msg_done    = a_fire & (locked ? (beats_left == 3'd1)
                                        : (grant_beats == 4'd1));

  // NOTE: sequential state is updated with non-blocking assignments only.
  // Every register then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      locked     <= 1'b0;
      held       <= 1'b0;
      owner      <= '0;
      beats_left <= '0;
    end else if (a_fire) begin
      held <= 1'b0;
      if (locked) begin
        beats_left <= beats_left - 3'd1;
        if (beats_left == 3'd1) locked <= 1'b0;
      end else if (grant_beats > 4'd1) begin
        locked     <= 1'b1;
        owner      <= grant;
        beats_left <= 3'(grant_beats - 4'd1);
      end
      if (msg_done) rr_ptr <= grant + REQ_BITS'(1);
    end else if (out_a_valid) begin
      // Stalled: pin the grant so the offered message cannot be swapped
      held  <= 1'b1;
      owner <= grant;
    end
  end

`ifdef TL_XING_ARB_PERF_EN
  logic [15:0] perf_cnt [NUM_REQ];

  // NOTE: this counter array is reset element by element. The counts must
  // start from a known 0, so it is not left to power-up state like a RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) perf_cnt[i] <= '0;
    end else if (msg_done && perf_cnt[grant] != 16'hFFFF) begin
      perf_cnt[grant] <= perf_cnt[grant] + 16'd1;
    end
  end

  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) perf_grants[16*i +: 16] = perf_cnt[i];
  end
`endif

  // D channel: steer by the index carried in the top source bits
  logic [REQ_BITS-1:0] d_idx;
  assign d_idx = out_d_bits_source[OUT_SRC_W-1 -: REQ_BITS];

  always_comb begin
    in_d_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      in_d_valid[i] = out_d_valid & (REQ_BITS'(i) == d_idx);
  end

  assign out_d_ready       = in_d_ready[d_idx];
  assign in_d_bits_opcode  = out_d_bits_opcode;
  assign in_d_bits_param   = out_d_bits_param;
  assign in_d_bits_size    = out_d_bits_size;
  assign in_d_bits_source  = out_d_bits_source[SRC_W-1:0];
  assign in_d_bits_sink    = out_d_bits_sink;
  assign in_d_bits_denied  = out_d_bits_denied;
  assign in_d_bits_data    = out_d_bits_data;
  assign in_d_bits_corrupt = out_d_bits_corrupt;

endmodule

// File: tb/tb_tl_xing_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tl_xing_rr_arbiter
//
// Self-checking bench for tl_xing_rr_arbiter, default parameters (2 clients,
// SRC_W=5, ADDR_W=31).
//
// Contents
//   - a table of D-steering vectors
//   - hand-written multi-cycle A-channel sequences: alternation, burst lock,
//     stall hold, reset mid-burst, and saturation when TL_XING_ARB_PERF_EN
//     is defined
//   - a randomized run against a message-level reference model
//
// Inputs change just after the rising edge. Outputs are sampled 2 ns later,
// away from the edge.
// ----------------------------------------------------------------------------
module tb_tl_xing_rr_arbiter;

  localparam int N = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  in_a_valid;
  logic [N-1:0]  in_a_ready;
  logic [3*N-1:0]  in_a_bits_opcode, in_a_bits_param, in_a_bits_size;
  logic [5*N-1:0]  in_a_bits_source;
  logic [31*N-1:0] in_a_bits_address;
  logic [8*N-1:0]  in_a_bits_mask;
  logic [64*N-1:0] in_a_bits_data;
  logic [N-1:0]    in_a_bits_corrupt;
  logic [N-1:0]    in_d_ready;
  logic [N-1:0]    in_d_valid;
  logic [2:0]      in_d_bits_opcode;
  logic [1:0]      in_d_bits_param;
  logic [2:0]      in_d_bits_size;
  logic [4:0]      in_d_bits_source;
  logic            in_d_bits_sink, in_d_bits_denied, in_d_bits_corrupt;
  logic [63:0]     in_d_bits_data;
  logic            out_a_valid, out_a_ready;
  logic [2:0]      out_a_bits_opcode, out_a_bits_param, out_a_bits_size;
  logic [5:0]      out_a_bits_source;
  logic [30:0]     out_a_bits_address;
  logic [7:0]      out_a_bits_mask;
  logic [63:0]     out_a_bits_data;
  logic            out_a_bits_corrupt;
  logic            out_d_valid, out_d_ready;
  logic [2:0]      out_d_bits_opcode;
  logic [1:0]      out_d_bits_param;
  logic [2:0]      out_d_bits_size;
  logic [5:0]      out_d_bits_source;
  logic            out_d_bits_sink, out_d_bits_denied, out_d_bits_corrupt;
  logic [63:0]     out_d_bits_data;
`ifdef TL_XING_ARB_PERF_EN
  logic [16*N-1:0] perf_grants;
`endif

  tl_xing_rr_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .in_a_valid         (in_a_valid),
    .in_a_ready         (in_a_ready),
    .in_a_bits_opcode   (in_a_bits_opcode),
    .in_a_bits_param    (in_a_bits_param),
    .in_a_bits_size     (in_a_bits_size),
    .in_a_bits_source   (in_a_bits_source),
    .in_a_bits_address  (in_a_bits_address),
    .in_a_bits_mask     (in_a_bits_mask),
    .in_a_bits_data     (in_a_bits_data),
    .in_a_bits_corrupt  (in_a_bits_corrupt),
    .in_d_ready         (in_d_ready),
    .in_d_valid         (in_d_valid),
    .in_d_bits_opcode   (in_d_bits_opcode),
    .in_d_bits_param    (in_d_bits_param),
    .in_d_bits_size     (in_d_bits_size),
    .in_d_bits_source   (in_d_bits_source),
    .in_d_bits_sink     (in_d_bits_sink),
    .in_d_bits_denied   (in_d_bits_denied),
    .in_d_bits_data     (in_d_bits_data),
    .in_d_bits_corrupt  (in_d_bits_corrupt),
    .out_a_valid        (out_a_valid),
    .out_a_ready        (out_a_ready),
    .out_a_bits_opcode  (out_a_bits_opcode),
    .out_a_bits_param   (out_a_bits_param),
    .out_a_bits_size    (out_a_bits_size),
    .out_a_bits_source  (out_a_bits_source),
    .out_a_bits_address (out_a_bits_address),
    .out_a_bits_mask    (out_a_bits_mask),
    .out_a_bits_data    (out_a_bits_data),
    .out_a_bits_corrupt (out_a_bits_corrupt),
    .out_d_valid        (out_d_valid),
    .out_d_ready        (out_d_ready),
    .out_d_bits_opcode  (out_d_bits_opcode),
    .out_d_bits_param   (out_d_bits_param),
    .out_d_bits_size    (out_d_bits_size),
    .out_d_bits_source  (out_d_bits_source),
    .out_d_bits_sink    (out_d_bits_sink),
    .out_d_bits_denied  (out_d_bits_denied),
    .out_d_bits_data    (out_d_bits_data),
    .out_d_bits_corrupt (out_d_bits_corrupt)
`ifdef TL_XING_ARB_PERF_EN
    ,
    .perf_grants        (perf_grants)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_client(input int i, input logic v, input logic [2:0] op,
                              input logic [2:0] sz, input logic [4:0] src);
    in_a_valid[i]               = v;
    in_a_bits_opcode[3*i +: 3]  = op;
    in_a_bits_size[3*i +: 3]    = sz;
    in_a_bits_source[5*i +: 5]  = src;
    in_a_bits_address[31*i +: 31] = 31'(32'h1000 * (i + 1));
    in_a_bits_data[64*i +: 64]  = {32'hC0DE0000 + 32'(i), 32'h1234_5678};
  endtask

  // Expect client g granted and offering a valid message
  task automatic check_grant(input string name, input int g);
    check({name, ".valid"}, 64'(out_a_valid), 64'd1);
    check({name, ".source"}, 64'(out_a_bits_source),
          64'({g[0], in_a_bits_source[5*g +: 5]}));
    check({name, ".ready"}, 64'(in_a_ready), out_a_ready ? 64'(1 << g) : 64'd0);
  endtask

  task automatic do_reset();
    in_a_valid  = '0;
    out_a_ready = 1'b0;
    reset       = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // Reference: data beats of a message from the opcode/size rules
  function automatic int ref_beats(input int op, input int sz);
    int s;
    s = (sz > 6) ? 6 : sz;
    if ((op == 0 || op == 1) && s > 3) return 2 ** (s - 3);
    return 1;
  endfunction

  typedef struct {
    logic       d_valid;
    logic [5:0] d_src;
    logic [1:0] d_ready;
    logic [1:0] exp_in_d_valid;
    logic       exp_out_d_ready;
    logic [4:0] exp_in_d_src;
  } d_vec_t;

  d_vec_t dvec [6];

  // Reference model state at message granularity
  int m_owner;   // client holding the port (stalled or mid-message), -1 if none
  int m_left;    // beats still owed by the current message, 0 if none started
  int m_pref;    // client preferred by the next free arbitration

  initial begin
    reset = 1'b1;
    in_a_valid = '0; in_a_bits_opcode = '0; in_a_bits_param = '0;
    in_a_bits_size = '0; in_a_bits_source = '0; in_a_bits_address = '0;
    in_a_bits_mask = '0; in_a_bits_data = '0; in_a_bits_corrupt = '0;
    in_d_ready = '0; out_a_ready = 1'b0;
    out_d_valid = 1'b0; out_d_bits_opcode = '0; out_d_bits_param = '0;
    out_d_bits_size = '0; out_d_bits_source = '0; out_d_bits_sink = 1'b0;
    out_d_bits_denied = 1'b0; out_d_bits_data = '0; out_d_bits_corrupt = 1'b0;

    dvec[0] = '{1'b1, 6'b1_00011, 2'b01, 2'b10, 1'b0, 5'd3};
    dvec[1] = '{1'b1, 6'b0_00111, 2'b01, 2'b01, 1'b1, 5'd7};
    dvec[2] = '{1'b0, 6'b1_11111, 2'b11, 2'b00, 1'b1, 5'd31};
    dvec[3] = '{1'b1, 6'b0_11111, 2'b10, 2'b01, 1'b0, 5'd31};
    dvec[4] = '{1'b1, 6'b1_00000, 2'b10, 2'b10, 1'b1, 5'd0};
    dvec[5] = '{1'b1, 6'b1_10101, 2'b00, 2'b10, 1'b0, 5'd21};

    // Reset state with inputs low
    next_cycle();
    settle();
    check("reset.out_a_valid", 64'(out_a_valid), 64'd0);
    check("reset.in_a_ready", 64'(in_a_ready), 64'd0);
    check("reset.in_d_valid", 64'(in_d_valid), 64'd0);
    do_reset();

    // D steering table
    for (int v = 0; v < 6; v++) begin
      out_d_valid       = dvec[v].d_valid;
      out_d_bits_source = dvec[v].d_src;
      in_d_ready        = dvec[v].d_ready;
      out_d_bits_data   = {32'(v), 32'hDEAD_BEEF};
      settle();
      check($sformatf("dvec%0d.in_d_valid", v), 64'(in_d_valid), 64'(dvec[v].exp_in_d_valid));
      check($sformatf("dvec%0d.out_d_ready", v), 64'(out_d_ready), 64'(dvec[v].exp_out_d_ready));
      check($sformatf("dvec%0d.in_d_source", v), 64'(in_d_bits_source), 64'(dvec[v].exp_in_d_src));
      check($sformatf("dvec%0d.in_d_data", v), in_d_bits_data, {32'(v), 32'hDEAD_BEEF});
      next_cycle();
    end
    out_d_valid = 1'b0;

    // Two single-beat Gets alternate 0,1,0,1
    do_reset();
    drive_client(0, 1'b1, 3'd4, 3'd3, 5'h0A);
    drive_client(1, 1'b1, 3'd4, 3'd3, 5'h15);
    out_a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check_grant($sformatf("alt%0d", k), k % 2);
      next_cycle();
    end

    // 4-beat PutFull from client 0 stays contiguous, then client 1
    do_reset();
    drive_client(0, 1'b1, 3'd0, 3'd5, 5'h03);
    drive_client(1, 1'b1, 3'd4, 3'd2, 5'h1C);
    out_a_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check_grant($sformatf("burst%0d", k), (k < 4) ? 0 : 1);
      next_cycle();
    end

    // Stalled client 1 keeps the grant when client 0 arrives
    do_reset();
    drive_client(0, 1'b0, 3'd4, 3'd3, 5'h01);
    drive_client(1, 1'b1, 3'd4, 3'd3, 5'h02);
    out_a_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_grant($sformatf("stall%0d", k), 1);
      next_cycle();
      in_a_valid[0] = 1'b1;
    end
    out_a_ready = 1'b1;
    settle();
    check_grant("stall.fire", 1);
    next_cycle();
    settle();
    check_grant("stall.after", 0);
    next_cycle();

    // Reset after the 2nd of 4 burst beats abandons the lock
    do_reset();
    drive_client(0, 1'b1, 3'd0, 3'd5, 5'h04);
    drive_client(1, 1'b1, 3'd4, 3'd3, 5'h05);
    out_a_ready = 1'b1;
    settle();
    check_grant("midrst.beat0", 0);
    next_cycle();
    settle();
    check_grant("midrst.beat1", 0);
    next_cycle();
    in_a_valid = '0;
    out_a_ready = 1'b0;
    reset = 1'b1;
    settle();
    check("midrst.out_a_valid", 64'(out_a_valid), 64'd0);
    check("midrst.in_a_ready", 64'(in_a_ready), 64'd0);
    next_cycle();
    reset = 1'b0;
    drive_client(0, 1'b1, 3'd4, 3'd3, 5'h06);
    drive_client(1, 1'b1, 3'd4, 3'd3, 5'h07);
    out_a_ready = 1'b1;
    settle();
    check_grant("midrst.next0", 0);
    next_cycle();
    settle();
    check_grant("midrst.next1", 1);
    next_cycle();

`ifdef TL_XING_ARB_PERF_EN
    // Saturating completion counters
    do_reset();
    drive_client(0, 1'b1, 3'd4, 3'd3, 5'h08);
    drive_client(1, 1'b0, 3'd4, 3'd3, 5'h09);
    out_a_ready = 1'b1;
    repeat (100) next_cycle();
    settle();
    check("perf.c0_100", 64'(perf_grants[15:0]), 64'd100);
    repeat (69900) next_cycle();
    settle();
    check("perf.c0_sat", 64'(perf_grants[15:0]), 64'hFFFF);
    check("perf.c1", 64'(perf_grants[31:16]), 64'd0);
`endif

    // Randomized run against the message-level model
    do_reset();
    m_owner = -1;
    m_left  = 0;
    m_pref  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      int ops[3];
      logic exp_valid;
      int idx;
      ops = '{0, 1, 4};
      for (int i = 0; i < N; i++) begin
        in_a_valid[i] = ($urandom_range(0, 9) < 7);
        in_a_bits_opcode[3*i +: 3]   = 3'(ops[$urandom_range(0, 2)]);
        in_a_bits_size[3*i +: 3]     = 3'($urandom_range(0, 7));
        in_a_bits_source[5*i +: 5]   = 5'($urandom);
        in_a_bits_address[31*i +: 31] = 31'($urandom);
        in_a_bits_data[64*i +: 64]   = {$urandom, $urandom};
      end
      out_a_ready       = ($urandom_range(0, 9) < 7);
      out_d_valid       = 1'($urandom);
      out_d_bits_source = 6'($urandom);
      in_d_ready        = 2'($urandom);
      settle();

      if (m_owner >= 0) begin
        g = m_owner;
      end else begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && in_a_valid[(m_pref + k) % N]) g = (m_pref + k) % N;
      end
      exp_valid = (g >= 0) ? in_a_valid[g] : 1'b0;

      check("rnd.out_a_valid", 64'(out_a_valid), 64'(exp_valid));
      check("rnd.in_a_ready", 64'(in_a_ready),
            (exp_valid && out_a_ready) ? 64'(1 << g) : 64'd0);
      if (exp_valid) begin
        check("rnd.source", 64'(out_a_bits_source), 64'({g[0], in_a_bits_source[5*g +: 5]}));
        check("rnd.address", 64'(out_a_bits_address), 64'(in_a_bits_address[31*g +: 31]));
        check("rnd.data", out_a_bits_data, in_a_bits_data[64*g +: 64]);
      end
      idx = int'(out_d_bits_source[5]);
      check("rnd.in_d_valid", 64'(in_d_valid), out_d_valid ? 64'(1 << idx) : 64'd0);
      check("rnd.out_d_ready", 64'(out_d_ready), 64'(in_d_ready[idx]));
      check("rnd.in_d_source", 64'(in_d_bits_source), 64'(out_d_bits_source[4:0]));

      if (exp_valid && out_a_ready) begin
        if (m_left == 0)
          m_left = ref_beats(int'(in_a_bits_opcode[3*g +: 3]), int'(in_a_bits_size[3*g +: 3]));
        m_left--;
        if (m_left == 0) begin
          m_pref  = (g + 1) % N;
          m_owner = -1;
        end else begin
          m_owner = g;
        end
      end else if (exp_valid) begin
        m_owner = g;
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
